// File: rtl/timer_pkg.sv
// Shared encodings for the countdown timer controller: FSM states, key codes
// and the 1 kHz -> 1 Hz prescaler terminal count.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  localparam logic [4:0] KEY_CLEAR  = 5'd10;
  localparam logic [4:0] KEY_START  = 5'd11;
  localparam logic [9:0] PRESC_LAST = 10'd999;

  function automatic logic is_digit(input logic [4:0] code);
    return code < 5'd10;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Start switch conditioner: 2-flop synchronizer, then a debounce filter sampled
// on the 1 kHz strobe; outputs the clean level and a one-cycle rising-edge pulse.
module sw_debounce #(
  parameter int DEB_CNT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pls_1k,
  input  logic sw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CNT + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      // cnt holds the run length of consecutive samples disagreeing with level
      if (pls_1k) begin
        if (sync_p1 == level) begin
          cnt <= '0;
        end else if (cnt == CW'(DEB_CNT - 1)) begin
          level <= sync_p1;
          rise  <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer control FSM: digit entry, 1 Hz tick generation, alarm timing.
// Define TIMER_CTRL_PAUSE_EN to let a start event in RUN pause the countdown.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int ALARM_SEC = 5,
  parameter int DEB_CNT   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pls_1k,
  input  logic       i_start_sw,
  input  logic       i_key_valid,
  input  logic [4:0] i_key_code,
  input  logic       i_zero,
  output logic       o_digit_wr,
  output logic [3:0] o_digit,
  output logic       o_clear,
  output logic       o_tick,
  output logic       o_run,
  output logic       o_alarm,
  output logic [2:0] o_state
);

  localparam int          DCW        = $clog2(DIGITS + 1);
  localparam logic [15:0] ALARM_LAST = 16'(ALARM_SEC * 1000 - 1);

  state_t           state;
  logic [DCW-1:0]   digit_cnt;
  logic [9:0]       presc;
  logic [15:0]      alarm_cnt;
  logic             deb_level;
  logic             deb_rise;
  logic             key_clear;
  logic             key_start;
  logic             key_digit;
  logic             start_evt;

  sw_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
    .clk    (i_clk),
    .rst    (i_rst),
    .pls_1k (i_pls_1k),
    .sw     (i_start_sw),
    .level  (deb_level),
    .rise   (deb_rise)
  );

  assign key_clear = i_key_valid && (i_key_code == KEY_CLEAR);
  assign key_start = i_key_valid && (i_key_code == KEY_START);
  assign key_digit = i_key_valid && is_digit(i_key_code);
  // rise only ever fires together with a high level; qualifying keeps both outputs live
  assign start_evt = (deb_rise && deb_level) || key_start;
  assign o_state   = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      digit_cnt  <= '0;
      presc      <= '0;
      alarm_cnt  <= '0;
      o_digit_wr <= 1'b0;
      o_digit    <= '0;
      o_clear    <= 1'b0;
      o_tick     <= 1'b0;
      o_run      <= 1'b0;
      o_alarm    <= 1'b0;
    end else begin
      o_digit_wr <= 1'b0;
      o_clear    <= 1'b0;
      o_tick     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_digit) begin
            o_digit_wr <= 1'b1;
            o_digit    <= i_key_code[3:0];
            digit_cnt  <= DCW'(1);
            state      <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (key_clear) begin
            o_clear   <= 1'b1;
            digit_cnt <= '0;
            state     <= ST_IDLE;
          end else if (start_evt && !i_zero) begin
            presc <= '0;
            o_run <= 1'b1;
            state <= ST_RUN;
          end else if (key_digit && (digit_cnt < DCW'(DIGITS))) begin
            o_digit_wr <= 1'b1;
            o_digit    <= i_key_code[3:0];
            digit_cnt  <= digit_cnt + DCW'(1);
          end
        end
        ST_RUN: begin
          if (key_clear) begin
            o_clear   <= 1'b1;
            digit_cnt <= '0;
            o_run     <= 1'b0;
            state     <= ST_IDLE;
          end else if (i_zero) begin
            alarm_cnt <= '0;
            o_run     <= 1'b0;
            o_alarm   <= 1'b1;
            state     <= ST_ALARM;
          end else begin
`ifdef TIMER_CTRL_PAUSE_EN
            if (start_evt) begin
              o_run <= 1'b0;
              state <= ST_PAUSE;
            end
`endif
            if (i_pls_1k) begin
              if (presc == PRESC_LAST) begin
                presc  <= '0;
                o_tick <= 1'b1;
              end else begin
                presc <= presc + 10'd1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (key_clear) begin
            o_clear   <= 1'b1;
            digit_cnt <= '0;
            state     <= ST_IDLE;
          end else if (start_evt) begin
            o_run <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_ALARM: begin
          if (i_key_valid || start_evt || (i_pls_1k && (alarm_cnt == ALARM_LAST))) begin
            o_clear <= 1'b1;
            o_alarm <= 1'b0;
            state   <= ST_IDLE;
          end else if (i_pls_1k) begin
            alarm_cnt <= alarm_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural reference model.
module tb_timer_ctrl;

  localparam int DIGITS    = 4;
  localparam int ALARM_SEC = 5;
  localparam int DEB_CNT   = 8;
`ifdef TIMER_CTRL_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_pls_1k = 1'b0;
  logic       i_start_sw = 1'b0;
  logic       i_key_valid = 1'b0;
  logic [4:0] i_key_code = 5'd0;
  logic       i_zero = 1'b0;
  logic       o_digit_wr;
  logic [3:0] o_digit;
  logic       o_clear;
  logic       o_tick;
  logic       o_run;
  logic       o_alarm;
  logic [2:0] o_state;

  timer_ctrl #(.DIGITS(DIGITS), .ALARM_SEC(ALARM_SEC), .DEB_CNT(DEB_CNT)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pls_1k    (i_pls_1k),
    .i_start_sw  (i_start_sw),
    .i_key_valid (i_key_valid),
    .i_key_code  (i_key_code),
    .i_zero      (i_zero),
    .o_digit_wr  (o_digit_wr),
    .o_digit     (o_digit),
    .o_clear     (o_clear),
    .o_tick      (o_tick),
    .o_run       (o_run),
    .o_alarm     (o_alarm),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain counters of pulses and a history of switch samples
  int m_st, m_ndig, m_run_pulses, m_alarm_pulses, e_digit;
  bit m_level, m_start_next, m_sw_d1, m_sw_d2;
  bit e_wr, e_clear, e_tick;
  bit m_samples[$];

  task automatic model_step();
    bit start, clr, dig, rise, all_diff;
    e_wr = 0; e_clear = 0; e_tick = 0;
    if (i_rst) begin
      m_st = 0; m_ndig = 0; m_run_pulses = 0; m_alarm_pulses = 0;
      m_level = 0; m_start_next = 0; m_sw_d1 = 0; m_sw_d2 = 0;
      m_samples.delete();
      return;
    end
    start = m_start_next || (i_key_valid && i_key_code == 5'd11);
    clr   = i_key_valid && i_key_code == 5'd10;
    dig   = i_key_valid && i_key_code < 5'd10;
    case (m_st)
      0: if (dig) begin e_wr = 1; e_digit = i_key_code; m_ndig = 1; m_st = 1; end
      1: begin
        if (clr) begin e_clear = 1; m_ndig = 0; m_st = 0; end
        else if (start && !i_zero) begin m_run_pulses = 0; m_st = 2; end
        else if (dig && m_ndig < DIGITS) begin e_wr = 1; e_digit = i_key_code; m_ndig++; end
      end
      2: begin
        if (clr) begin e_clear = 1; m_ndig = 0; m_st = 0; end
        else if (i_zero) begin m_alarm_pulses = 0; m_st = 4; end
        else begin
          if (start && PAUSE_EN) m_st = 3;
          if (i_pls_1k) begin
            m_run_pulses++;
            if (m_run_pulses == 1000) begin e_tick = 1; m_run_pulses = 0; end
          end
        end
      end
      3: begin
        if (clr) begin e_clear = 1; m_ndig = 0; m_st = 0; end
        else if (start) m_st = 2;
      end
      4: begin
        if (i_key_valid || start) begin e_clear = 1; m_st = 0; end
        else if (i_pls_1k) begin
          m_alarm_pulses++;
          if (m_alarm_pulses == ALARM_SEC * 1000) begin e_clear = 1; m_st = 0; end
        end
      end
      default: m_st = 0;
    endcase
    // Debounce: level flips once the last DEB_CNT samples all disagree with it
    rise = 0;
    if (i_pls_1k) begin
      m_samples.push_back(m_sw_d2);
      if (m_samples.size() > DEB_CNT) void'(m_samples.pop_front());
      if (m_samples.size() == DEB_CNT) begin
        all_diff = 1;
        foreach (m_samples[i]) if (m_samples[i] == m_level) all_diff = 0;
        if (all_diff) begin m_level = !m_level; rise = m_level; end
      end
    end
    m_sw_d2 = m_sw_d1;
    m_sw_d1 = i_start_sw;
    m_start_next = rise;
  endtask

  task automatic step();
    model_step();
    @(posedge i_clk);
    #1;
    check_eq("state", o_state, m_st);
    check_eq("run", o_run, int'(m_st == 2));
    check_eq("alarm", o_alarm, int'(m_st == 4));
    check_eq("clear", o_clear, e_clear);
    check_eq("tick", o_tick, e_tick);
    check_eq("digit_wr", o_digit_wr, e_wr);
    if (e_wr) check_eq("digit", o_digit, e_digit);
    i_key_valid = 0;
    i_pls_1k = 0;
    i_rst = 0;
  endtask

  task automatic key(input int code);
    i_key_valid = 1;
    i_key_code = 5'(code);
    step();
    step();
  endtask

  task automatic do_reset();
    i_rst = 1; step();
    i_rst = 1; step();
  endtask

  task automatic sample_sw(input bit v);
    i_start_sw = v;
    repeat (3) step();
    i_pls_1k = 1;
    step();
  endtask

  initial begin
    int wr_cnt, pulses, ticks, prev, first, clears, changes, last_st;
    bit hit;
    int digits[$];

    // Reset state
    i_rst = 1; step();
    i_rst = 1; step();
    check_eq("rst_state", o_state, 0);
    check_eq("rst_alarm", o_alarm, 0);

    // Five digits then start: only four accepted
    wr_cnt = 0;
    for (int d = 1; d <= 5; d++) begin
      i_key_valid = 1; i_key_code = 5'(d);
      step();
      if (o_digit_wr) begin wr_cnt++; digits.push_back(o_digit); end
      step();
    end
    check_eq("entry_wr_count", wr_cnt, 4);
    foreach (digits[i]) check_eq("entry_digit", digits[i], i + 1);
    key(11);
    check_eq("entry_to_run", o_state, 2);

    // Three ticks, 1000 pulses apart
    pulses = 0; ticks = 0; prev = 0; first = 0;
    for (int c = 0; c < 20000 && pulses < 3000; c++) begin
      i_pls_1k = $urandom_range(0, 1);
      if (i_pls_1k) pulses++;
      step();
      if (o_tick) begin
        ticks++;
        if (ticks == 1) first = pulses;
        else check_eq("tick_spacing", pulses - prev, 1000);
        prev = pulses;
      end
    end
    check_eq("tick_count", ticks, 3);
    check_eq("first_tick_pulse", first, 1000);

    // Zero -> ALARM next cycle, then timed exit
    i_zero = 1; step(); i_zero = 0;
    check_eq("zero_to_alarm", o_state, 4);
    pulses = 0; clears = 0;
    for (int c = 0; c < 20000 && o_state == 3'd4; c++) begin
      i_pls_1k = $urandom_range(0, 1);
      if (i_pls_1k) pulses++;
      step();
      if (o_clear) clears++;
    end
    check_eq("alarm_pulses", pulses, ALARM_SEC * 1000);
    check_eq("alarm_clear_cnt", clears, 1);
    check_eq("alarm_exit_state", o_state, 0);

    // Bouncing switch in RUN yields exactly one start event
    do_reset();
    key(7); key(11);
    for (int i = 0; i < 300; i++) begin i_pls_1k = 1; step(); end
    changes = 0; last_st = o_state;
    for (int i = 0; i < 5; i++) begin
      sample_sw(i % 2);
      if (o_state != last_st) changes++;
      last_st = o_state;
    end
    for (int i = 0; i < 8 + 2; i++) begin
      sample_sw(1);
      if (o_state != last_st) changes++;
      last_st = o_state;
    end
    check_eq("bounce_state_changes", changes, PAUSE_EN ? 1 : 0);
    check_eq("bounce_state", o_state, PAUSE_EN ? 3 : 2);
    ticks = 0;
    for (int i = 0; i < 800; i++) begin
      i_pls_1k = 1; step();
      if (o_tick) ticks++;
    end
    check_eq("pause_hold_ticks", ticks, PAUSE_EN ? 0 : 1);
    for (int i = 0; i < 10; i++) sample_sw(0);
    check_eq("sw_release_state", o_state, PAUSE_EN ? 3 : 2);

    // Clear key coincident with a switch start event in RUN
    do_reset();
    key(3); key(11);
    i_start_sw = 1; hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      i_pls_1k = 1;
      if (m_start_next) begin i_key_valid = 1; i_key_code = 5'd10; hit = 1; end
      step();
    end
    check_eq("clr_start_hit", hit, 1);
    check_eq("clr_start_clear", o_clear, 1);
    check_eq("clr_start_state", o_state, 0);
    step();
    check_eq("clr_start_no_pause", o_state, 0);

    // Reset during ALARM: immediate IDLE, no clear pulse
    i_start_sw = 0;
    do_reset();
    key(5); key(11);
    i_zero = 1; step(); i_zero = 0;
    for (int i = 0; i < 100; i++) begin i_pls_1k = 1; step(); end
    check_eq("pre_rst_alarm", o_state, 4);
    i_rst = 1; step();
    check_eq("rst_alarm_off", o_alarm, 0);
    check_eq("rst_alarm_state", o_state, 0);
    check_eq("rst_alarm_no_clear", o_clear, 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      i_rst       = ($urandom_range(0, 999) == 0);
      i_pls_1k    = $urandom_range(0, 1);
      i_key_valid = ($urandom_range(0, 9) == 0);
      i_key_code  = 5'($urandom_range(0, 15));
      i_zero      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) i_start_sw = ~i_start_sw;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset, i_clk and i_rst; i_clk SHALL be the only clock.
REQ-002 Parameter DIGITS, default 4, SHALL set the maximum number of entry digits accepted.
REQ-003 Parameter ALARM_SEC, default 5, SHALL set the alarm duration in seconds (range 1..60).
REQ-004 Parameter DEB_CNT, default 8, SHALL set the start-switch debounce length in 1 kHz samples.
REQ-005 i_clk  in  1  system clock.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_pls_1k  in  1  single-cycle 1 kHz enable strobe.
REQ-008 i_start_sw  in  1  raw start/stop switch level, asynchronous to i_clk.
REQ-009 i_key_valid  in  1  single-cycle key strobe.
REQ-010 i_key_code  in  5  key code: 0..9 digit, 10 clear, 11 start/stop, others ignored.
REQ-011 i_zero  in  1  datapath count equals zero.
REQ-012 o_digit_wr  out  1  single-cycle strobe: shift o_digit into the datapath.
REQ-013 o_digit  out  4  BCD digit to shift in.
REQ-014 o_clear  out  1  single-cycle strobe: clear the datapath count.
REQ-015 o_tick  out  1  single-cycle 1 Hz strobe: decrement the datapath count.
REQ-016 o_run  out  1  high in RUN.
REQ-017 o_alarm  out  1  high in ALARM; drives buzzer and LED enable.
REQ-018 o_state  out  3  current state: IDLE=0, ENTRY=1, RUN=2, PAUSE=3, ALARM=4.

Function
REQ-019 i_start_sw SHALL pass through a 2-flop synchronizer, then be sampled on i_pls_1k; the debounced level SHALL change only after DEB_CNT consecutive equal samples.
REQ-020 A start event SHALL be a one-cycle pulse on a debounced 0->1 edge, or on i_key_valid with code 11.
REQ-021 IDLE: a digit key SHALL pulse o_digit_wr with o_digit=code, set the digit count to 1 and go to ENTRY; start and clear SHALL be ignored.
REQ-022 ENTRY: a digit key SHALL pulse o_digit_wr when the digit count < DIGITS; further digits SHALL be ignored with no strobe.
REQ-023 ENTRY: a start event with i_zero=0 SHALL go to RUN and clear the prescaler; with i_zero=1 it SHALL be ignored.
REQ-024 Clear key (code 10) in ENTRY, RUN or PAUSE SHALL pulse o_clear, reset the digit count and go to IDLE.
REQ-025 RUN: a 10-bit prescaler SHALL count i_pls_1k; on the 1000th pulse it SHALL assert o_tick for one cycle and wrap to 0.
REQ-026 RUN: i_zero=1 SHALL go to ALARM on the next cycle; no further o_tick SHALL issue.
REQ-027 RUN: a start event SHALL go to PAUSE; PAUSE SHALL hold the prescaler value, and a start event in PAUSE SHALL resume RUN from the held value.
REQ-028 ALARM: o_alarm SHALL be high for ALARM_SEC*1000 i_pls_1k pulses, then o_clear SHALL pulse and the state SHALL go to IDLE.
REQ-029 ALARM: any i_key_valid or start event SHALL end the alarm early, pulse o_clear and go to IDLE.
REQ-030 Priority in one cycle SHALL be clear key > i_zero > start event > digit.
REQ-031 All strobes SHALL be registered and occur one cycle after the causing input.

Reset
REQ-032 While i_rst is high, state SHALL be IDLE and all outputs 0.
REQ-033 While i_rst is high, the prescaler, alarm counter, digit count and debounce state SHALL be 0.
REQ-034 Reset SHALL take effect from any state, mid-count included, on the next i_clk edge.

Configuration
REQ-035 Macro TIMER_CTRL_PAUSE_EN defined SHALL enable PAUSE as specified.
REQ-036 Without TIMER_CTRL_PAUSE_EN, a start event in RUN SHALL be ignored and state 3 SHALL be unreachable.

Structure
REQ-037 Package timer_pkg SHALL hold the state encoding, the key-code constants (10, 11) and the prescaler terminal value 999.
REQ-038 The synchronizer and debounce SHALL be one sub-module, sw_debounce, with a debounced level output and a rising-edge pulse output.

Verification
REQ-039 Keys 1,2,3,4,5 then start with i_zero=0 -> four o_digit_wr pulses with digits 1,2,3,4, no fifth pulse, o_state=2.
REQ-040 RUN for 3000 i_pls_1k pulses -> exactly 3 o_tick pulses, 1000 pulses apart.
REQ-041 In RUN, assert i_zero -> o_state=4 next cycle; after 5000 pulses -> o_clear pulse, o_state=0.
REQ-042 Switch bouncing 0/1 for 5 samples, then high for 8 samples -> exactly one start event; with TIMER_CTRL_PAUSE_EN, RUN->PAUSE, prescaler frozen at its value.
REQ-043 Clear key and start key in the same cycle in RUN -> o_clear pulse, o_state=0, no PAUSE.
REQ-044 Assert i_rst during ALARM -> o_alarm=0 and o_state=0 on the next edge, with no o_clear pulse.
